// File: rtl/byte_unstriping.sv
// byte_unstriping
//   Receive-side lane merger: four byte lanes, each with its own valid, are
//   buffered in per-lane FIFOs and re-serialized in strict lane order
//   0,1,2,3,0,... onto a single valid/ready byte stream.
//
//   Optional feature macro: UNSTRIPE_STATS_EN
//     defined   -> adds output byteCount[15:0], a wrapping count of accepted
//                  output bytes.
//     undefined -> byteCount port and its logic are absent.
//
//   Output handshake: byteUnstripingOUT is meaningful only while
//   byteUnstripingVLD=1. A byte is transferred on a posedge where VLD and RDY
//   are both 1. Once VLD rises, VLD and OUT stay unchanged until that transfer
//   happens; VLD never depends combinationally on RDY.
//
//   Lane inputs have no ready. laneFull[N] is the backpressure hint for lane N.
//   A byte offered to a full lane is dropped unless that lane pops on the same
//   edge, and a drop sets the sticky overflowErr flag.

module byte_unstriping #(
    parameter int LANE_FIFO_DEPTH = 4,
    parameter int DATA_W          = 8
) (
    input  logic              clk1Mhz,
    input  logic              reset_L,
    input  logic [DATA_W-1:0] stripedLane0,
    input  logic [DATA_W-1:0] stripedLane1,
    input  logic [DATA_W-1:0] stripedLane2,
    input  logic [DATA_W-1:0] stripedLane3,
    input  logic              lane0VLD,
    input  logic              lane1VLD,
    input  logic              lane2VLD,
    input  logic              lane3VLD,
    output logic [3:0]        laneFull,
    output logic [DATA_W-1:0] byteUnstripingOUT,
    output logic              byteUnstripingVLD,
    input  logic              byteUnstripingRDY,
    output logic [1:0]        counter,
    output logic              overflowErr
`ifdef UNSTRIPE_STATS_EN
    ,
    output logic [15:0]       byteCount
`endif
);

    localparam int PTR_W = $clog2(LANE_FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    // Lane inputs gathered into vectors so the per-lane logic can be generated.
    logic [3:0]             lane_vld;
    logic [3:0][DATA_W-1:0] lane_data;
    logic [3:0][DATA_W-1:0] lane_head;
    logic [3:0]             lane_full;
    logic [3:0]             lane_empty;
    logic [3:0]             push;
    logic [3:0]             pop;
    logic                   load;
    logic                   drop;

    assign lane_vld  = {lane3VLD, lane2VLD, lane1VLD, lane0VLD};
    assign lane_data = {stripedLane3, stripedLane2, stripedLane1, stripedLane0};
    assign laneFull  = lane_full;

    // Output register loads whenever it is free (empty or being accepted now)
    // and the lane the pointer names has data. Other lanes are never consulted,
    // which keeps the byte order strict even under skew. A lane can accept a
    // byte when full only if it is the one being popped this edge.
    always_comb begin
        load = 1'b0;
        pop  = '0;
        push = '0;
        drop = 1'b0;
        load = (!byteUnstripingVLD || byteUnstripingRDY) && !lane_empty[counter];
        if (load) begin
            pop[counter] = 1'b1;
        end
        push = lane_vld & (~lane_full | pop);
        drop = |(lane_vld & ~push);
    end

    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [DATA_W-1:0] mem [LANE_FIFO_DEPTH];
        logic [PTR_W-1:0]  wr_ptr;
        logic [PTR_W-1:0]  rd_ptr;
        logic [OCC_W-1:0]  occ;

        // Full/empty come straight from the registered occupancy: no lookahead.
        assign lane_full[g]  = (occ == OCC_W'(LANE_FIFO_DEPTH));
        assign lane_empty[g] = (occ == '0);
        assign lane_head[g]  = mem[rd_ptr];

        // Storage array; contents are don't-care until written, so no reset.
        always_ff @(posedge clk1Mhz) begin
            if (push[g]) begin
                mem[wr_ptr] <= lane_data[g];
            end
        end

        // Pointers and occupancy; pointers wrap naturally at the FIFO depth.
        always_ff @(posedge clk1Mhz or negedge reset_L) begin
            if (!reset_L) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                occ    <= '0;
            end else begin
                if (push[g]) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop[g]) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({push[g], pop[g]})
                    2'b10:   occ <= occ + OCC_W'(1);
                    2'b01:   occ <= occ - OCC_W'(1);
                    default: occ <= occ;
                endcase
            end
        end
    end

    // Single output register plus the lane pointer that advances on every load.
    always_ff @(posedge clk1Mhz or negedge reset_L) begin
        if (!reset_L) begin
            byteUnstripingOUT <= '0;
            byteUnstripingVLD <= 1'b0;
            counter           <= 2'd0;
        end else if (load) begin
            byteUnstripingOUT <= lane_head[counter];
            byteUnstripingVLD <= 1'b1;
            counter           <= counter + 2'd1;
        end else if (byteUnstripingRDY) begin
            byteUnstripingVLD <= 1'b0;
        end
    end

    // Sticky record that at least one lane byte was lost since reset.
    always_ff @(posedge clk1Mhz or negedge reset_L) begin
        if (!reset_L) begin
            overflowErr <= 1'b0;
        end else if (drop) begin
            overflowErr <= 1'b1;
        end
    end

`ifdef UNSTRIPE_STATS_EN
    // Wrapping count of bytes accepted by the consumer.
    always_ff @(posedge clk1Mhz or negedge reset_L) begin
        if (!reset_L) begin
            byteCount <= 16'd0;
        end else if (byteUnstripingVLD && byteUnstripingRDY) begin
            byteCount <= byteCount + 16'd1;
        end
    end
`endif

endmodule
